decoder_in_conditioner: RTL and testbench

Input conditioning stage directly upstream of `decoder_proj`. Synchronises the asynchronous 7-bit `io_in` pad bus into the `clock` domain and debounces it. Each new stable code word is presented to the decoder over a valid/ready handshake, and a sticky flag records codes that are dropped because the decoder was still busy.

---
 rtl/decoder_proj_pkg.sv | 17 +
 rtl/sync_chain.sv | 25 ++
 rtl/decoder_in_conditioner.sv | 124 ++++++++++++
 tb/tb_decoder_in_conditioner.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_proj_pkg.sv
// Shared types and constants for the decoder_proj input path.
// Holds the code width, presenter FSM states and a counter sizing helper.
package decoder_proj_pkg;

    localparam int DECODER_CODE_W = 7;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Bits needed to count 0..depth-1; never less than one.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Per-bit flop chain for bringing asynchronous inputs into a clock domain.
// Resets asynchronously to zero; q is the last stage.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/decoder_in_conditioner.sv
// Synchronises and debounces the decoder pad bus, then presents each new
// stable code over valid/ready, flagging codes dropped while busy.
module decoder_in_conditioner
    import decoder_proj_pkg::*;
#(
    parameter int WIDTH       = DECODER_CODE_W,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] code_o,
    output logic             code_valid_o,
    input  logic             code_ready_i,
    output logic             overrun_o,
    input  logic             clear_overrun_i
);

    localparam int CW = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] last;
    logic [CW-1:0]    cnt;
    logic             stable;
    logic             code_evt;
    state_t           state_q;
    state_t           state_d;
    logic             load_code;
    logic             set_ovr;

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (io_in),
        .q       (sync)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sync != cand) begin
            cand <= sync;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign stable   = (sync == cand) && (cnt == CNT_MAX);
    assign code_evt = stable && (cand != last);

    // last moves on every event, even a dropped one, so each value fires once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last <= '0;
        end else if (code_evt) begin
            last <= cand;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_code = 1'b0;
        set_ovr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (code_evt) begin
                    load_code = 1'b1;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                if (code_ready_i) begin
                    if (code_evt) begin
                        load_code = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (code_evt) begin
                    set_ovr = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        code_valid_o = (state_q == PRESENT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_o <= '0;
        end else if (load_code) begin
            code_o <= cand;
        end
    end

    // a fresh drop outranks a clear arriving on the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun_o <= 1'b0;
        end else if (set_ovr) begin
            overrun_o <= 1'b1;
        end else if (clear_overrun_i) begin
            overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_in_conditioner.sv
// Randomised and directed bench for decoder_in_conditioner against a
// run-length based reference model of the debounce and handshake rules.
module tb_decoder_in_conditioner;

    localparam int W = 7;
    localparam int S = 2;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] io_in = '0;
    logic [W-1:0] code_o;
    logic         code_valid_o;
    logic         code_ready_i = 1'b0;
    logic         overrun_o;
    logic         clear_overrun_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    decoder_in_conditioner #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .DEBOUNCE    (D)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .io_in           (io_in),
        .code_o          (code_o),
        .code_valid_o    (code_valid_o),
        .code_ready_i    (code_ready_i),
        .overrun_o       (overrun_o),
        .clear_overrun_i (clear_overrun_i)
    );

    always #5 clock = ~clock;

    // Reference model: delay line, run length of identical samples, flags.
    logic [W-1:0] dq[$];
    logic [W-1:0] run_v;
    int           run_len;
    logic [W-1:0] last_m;
    logic [W-1:0] code_m;
    bit           valid_m;
    bit           ovr_m;
    logic [W-1:0] m_s;
    bit           m_ev;
    bit           m_was;
    bit           m_set;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dq.delete();
            repeat (S) dq.push_back('0);
            run_v   = '0;
            run_len = 1;
            last_m  = '0;
            code_m  = '0;
            valid_m = 0;
            ovr_m   = 0;
        end else begin
            m_s = dq.pop_front();
            dq.push_back(io_in);
            if (m_s == run_v) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_v   = m_s;
                run_len = 1;
            end
            m_ev  = (run_len >= D + 1) && (m_s != last_m);
            m_was = valid_m;
            m_set = 0;
            if (m_was && code_ready_i) valid_m = 0;
            if (m_ev) begin
                last_m = m_s;
                if (!m_was || code_ready_i) begin
                    code_m  = m_s;
                    valid_m = 1;
                end else begin
                    m_set = 1;
                end
            end
            if (m_set) ovr_m = 1;
            else if (clear_overrun_i) ovr_m = 0;
        end
    end

    function automatic logic [W-1:0] pick(input logic [W-1:0] a);
        logic [W-1:0] v;
        do v = W'($urandom); while (v == a || v == '0);
        return v;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        io_in = '0;
        code_ready_i = 1'b0;
        clear_overrun_i = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (code_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", code_valid_o);
        end
        n_cmp++;
        if (overrun_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ovr: got %b want 0", overrun_o);
        end
        n_cmp++;
        if (code_o !== '0) begin
            n_bad++;
            $display("FAIL reset_code: got %b want 0", code_o);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_code();
        io_in = 7'b1100010;
        code_ready_i = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            n_cmp++;
            if (code_valid_o !== 1'(c == 7)) begin
                n_bad++;
                $display("FAIL latency c%0d: valid=%b want %b",
                         c, code_valid_o, (c == 7));
            end
            if (c == 7) begin
                n_cmp++;
                if (code_o !== 7'b1100010) begin
                    n_bad++;
                    $display("FAIL single_code: got %b want 1100010", code_o);
                end
            end
            n_cmp++;
            if (overrun_o !== 1'b0) begin
                n_bad++;
                $display("FAIL single_ovr c%0d: got %b want 0", c, overrun_o);
            end
        end
    endtask

    task automatic test_glitch();
        io_in = '0;
        code_ready_i = 1'b1;
        for (int c = 0; c < 27; c++) begin
            if (c == 12) io_in = 7'b1111111;
            if (c == 15) io_in = 7'b0000000;
            @(negedge clock);
            n_cmp++;
            if (code_valid_o !== valid_m || overrun_o !== ovr_m ||
                (valid_m && code_o !== code_m)) begin
                n_bad++;
                $display("FAIL model_glitch: v=%b o=%b c=%b want v=%b o=%b c=%b",
                         code_valid_o, overrun_o, code_o, valid_m, ovr_m, code_m);
            end
            if (c >= 12) begin
                n_cmp++;
                if (code_valid_o !== 1'b0 || overrun_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL glitch c%0d: valid=%b ovr=%b want 0 0",
                             c, code_valid_o, overrun_o);
                end
            end
        end
    endtask

    task automatic test_overrun();
        code_ready_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            io_in = (c < 10) ? 7'b1100010 : 7'b0011101;
            @(negedge clock);
            n_cmp++;
            if (code_valid_o !== valid_m || overrun_o !== ovr_m ||
                (valid_m && code_o !== code_m)) begin
                n_bad++;
                $display("FAIL model_overrun: v=%b o=%b c=%b want v=%b o=%b c=%b",
                         code_valid_o, overrun_o, code_o, valid_m, ovr_m, code_m);
            end
        end
        n_cmp++;
        if (code_valid_o !== 1'b1 || code_o !== 7'b1100010 || overrun_o !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_hold: v=%b c=%b o=%b want 1 1100010 1",
                     code_valid_o, code_o, overrun_o);
        end
        code_ready_i = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clock);
            n_cmp++;
            if (code_valid_o !== 1'b0 || overrun_o !== 1'b1) begin
                n_bad++;
                $display("FAIL overrun_drain c%0d: v=%b o=%b want 0 1",
                         c, code_valid_o, overrun_o);
            end
        end
    endtask

    task automatic test_clear_collision();
        logic [W-1:0] a;
        logic [W-1:0] b;
        clear_overrun_i = 1'b1;
        @(negedge clock);
        clear_overrun_i = 1'b0;
        n_cmp++;
        if (overrun_o !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_first: got %b want 0", overrun_o);
        end
        code_ready_i = 1'b0;
        a = pick(last_m);
        b = pick(a);
        io_in = a;
        repeat (10) @(negedge clock);
        io_in = b;
        for (int c = 1; c <= 7; c++) begin
            if (c == 7) clear_overrun_i = 1'b1;
            @(negedge clock);
            n_cmp++;
            if (code_valid_o !== valid_m || overrun_o !== ovr_m ||
                (valid_m && code_o !== code_m)) begin
                n_bad++;
                $display("FAIL model_clear: v=%b o=%b c=%b want v=%b o=%b c=%b",
                         code_valid_o, overrun_o, code_o, valid_m, ovr_m, code_m);
            end
        end
        n_cmp++;
        if (overrun_o !== 1'b1 || code_valid_o !== 1'b1 || code_o !== a) begin
            n_bad++;
            $display("FAIL set_beats_clear: o=%b v=%b c=%b want 1 1 %b",
                     overrun_o, code_valid_o, code_o, a);
        end
        @(negedge clock);
        clear_overrun_i = 1'b0;
        n_cmp++;
        if (overrun_o !== 1'b0) begin
            n_bad++;
            $display("FAIL later_clear: got %b want 0", overrun_o);
        end
        code_ready_i = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        code_ready_i = 1'b0;
        a = pick(last_m);
        b = pick(a);
        io_in = a;
        repeat (10) @(negedge clock);
        io_in = b;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) code_ready_i = 1'b1;
            @(negedge clock);
            n_cmp++;
            if (code_valid_o !== valid_m || overrun_o !== ovr_m ||
                (valid_m && code_o !== code_m)) begin
                n_bad++;
                $display("FAIL model_b2b: v=%b o=%b c=%b want v=%b o=%b c=%b",
                         code_valid_o, overrun_o, code_o, valid_m, ovr_m, code_m);
            end
            if (c >= 6) begin
                n_cmp++;
                if (code_valid_o !== 1'(c <= 7) ||
                    (c <= 7 && code_o !== ((c == 6) ? a : b))) begin
                    n_bad++;
                    $display("FAIL b2b c%0d: v=%b c=%b want v=%b c=%b", c,
                             code_valid_o, code_o, (c <= 7), (c == 6) ? a : b);
                end
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                io_in = W'($urandom);
                if ($urandom_range(3, 0) == 0) io_in = last_m;
                hold = $urandom_range(10, 1);
            end
            hold--;
            code_ready_i = 1'($urandom);
            clear_overrun_i = ($urandom_range(9, 0) == 0);
            @(negedge clock);
            n_cmp++;
            if (code_valid_o !== valid_m || overrun_o !== ovr_m ||
                (valid_m && code_o !== code_m)) begin
                n_bad++;
                $display("FAIL model_random c%0d: v=%b o=%b c=%b want v=%b o=%b c=%b",
                         c, code_valid_o, overrun_o, code_o, valid_m, ovr_m, code_m);
            end
        end
        clear_overrun_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        code_ready_i = 1'b0;
        io_in = pick(last_m);
        repeat (10) @(negedge clock);
        n_cmp++;
        if (code_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_present: got %b want 1", code_valid_o);
        end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (code_valid_o !== 1'b0 || code_o !== '0 || overrun_o !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: v=%b c=%b o=%b want 0 0 0",
                     code_valid_o, code_o, overrun_o);
        end
        io_in = '0;
        @(negedge clock);
        reset_n = 1'b1;
        code_ready_i = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            n_cmp++;
            if (code_valid_o !== 1'b0 || code_valid_o !== valid_m) begin
                n_bad++;
                $display("FAIL zero_after_reset c%0d: v=%b want 0", c, code_valid_o);
            end
        end
        io_in = 7'b1100010;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            n_cmp++;
            if (code_valid_o !== 1'(c == 7) || (c == 7 && code_o !== 7'b1100010)) begin
                n_bad++;
                $display("FAIL relatch c%0d: v=%b c=%b want %b 1100010",
                         c, code_valid_o, code_o, (c == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_code();
        test_glitch();
        test_overrun();
        test_clear_collision();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
